// File: rtl/fft_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// A DEPTH-entry delay line holds the first half of each block. While the
// second half streams in, the stage emits the half-sums directly and stores
// the half-differences back into the line. Flush cycles drain those stored
// differences. Every output is registered, so data appears one clock after
// sel/in.
module fft_sdf_stage #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   input  logic              in_valid,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic              out_valid
);

   localparam logic [1:0] SEL_FILL = 2'd0;
   localparam logic [1:0] SEL_BFLY = 2'd1;

   // Entry DEPTH-1 is the head (oldest); entry 0 is the tail (newest).
   logic [DATA_W-1:0] dl_re [DEPTH];
   logic [DATA_W-1:0] dl_im [DEPTH];
   logic              dl_v  [DEPTH];

   logic [DATA_W-1:0] head_re, head_im;
   logic              head_v;

   // Sums and differences are one bit wider so they cannot overflow. Taking
   // bits [DATA_W:1] is an arithmetic shift right by one, which rounds
   // toward minus infinity.
   logic [DATA_W:0]   sum_re_w, sum_im_w, diff_re_w, diff_im_w;

   logic [DATA_W-1:0] tail_re, tail_im;
   logic              tail_v;
   logic [DATA_W-1:0] nxt_re, nxt_im;
   logic              nxt_v;

   assign head_re = dl_re[DEPTH-1];
   assign head_im = dl_im[DEPTH-1];
   assign head_v  = dl_v[DEPTH-1];

   assign sum_re_w  = {head_re[DATA_W-1], head_re} + {in_re[DATA_W-1], in_re};
   assign sum_im_w  = {head_im[DATA_W-1], head_im} + {in_im[DATA_W-1], in_im};
   assign diff_re_w = {head_re[DATA_W-1], head_re} - {in_re[DATA_W-1], in_re};
   assign diff_im_w = {head_im[DATA_W-1], head_im} - {in_im[DATA_W-1], in_im};

   // Decode sel into the value pushed at the tail and the next output word.
   always_comb begin
      tail_re = '0;
      tail_im = '0;
      tail_v  = 1'b0;
      nxt_re  = head_re;
      nxt_im  = head_im;
      nxt_v   = head_v;
      case (sel)
         SEL_FILL: begin
            tail_re = in_re;
            tail_im = in_im;
            tail_v  = in_valid;
         end
         SEL_BFLY: begin
            tail_re = diff_re_w[DATA_W:1];
            tail_im = diff_im_w[DATA_W:1];
            tail_v  = in_valid;
            nxt_re  = sum_re_w[DATA_W:1];
            nxt_im  = sum_im_w[DATA_W:1];
            nxt_v   = in_valid;
         end
         default: begin
            // Flush (sel 2 or 3): inputs ignored, zeros pushed, head emitted.
         end
      endcase
   end

   // Delay line advances by exactly one entry every cycle; reset empties it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            dl_re[i] <= '0;
            dl_im[i] <= '0;
            dl_v[i]  <= 1'b0;
         end
      end else begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            dl_re[i] <= dl_re[i-1];
            dl_im[i] <= dl_im[i-1];
            dl_v[i]  <= dl_v[i-1];
         end
         dl_re[0] <= tail_re;
         dl_im[0] <= tail_im;
         dl_v[0]  <= tail_v;
      end
   end

   // Output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_re    <= '0;
         out_im    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_re    <= nxt_re;
         out_im    <= nxt_im;
         out_valid <= nxt_v;
      end
   end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Self-checking bench for fft_sdf_stage: directed and random steps compared
// against a queue-based reference model of the delay-feedback stage.
module tb_fft_sdf_stage;

   localparam int W = 16;
   localparam int D = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   sel;
   logic [W-1:0] in_re, in_im;
   logic         in_valid;
   logic [W-1:0] out_re, out_im;
   logic         out_valid;

   fft_sdf_stage #(.DATA_W(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .sel(sel),
      .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
      .out_re(out_re), .out_im(out_im), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int re;
      int im;
      bit v;
   } ent_t;

   ent_t q[$];
   int   exp_re, exp_im;
   bit   exp_v;
   int   vectors = 0;
   int   miscompares = 0;

   logic [W-1:0] rec2_re [2*D];
   logic [W-1:0] rec3_re [2*D];
   logic [W-1:0] rec2_im [2*D];
   logic [W-1:0] rec3_im [2*D];

   task automatic model_reset();
      ent_t z;
      z.re = 0; z.im = 0; z.v = 1'b0;
      q.delete();
      for (int i = 0; i < D; i++) q.push_back(z);
      exp_re = 0; exp_im = 0; exp_v = 1'b0;
   endtask

   // One clock of the reference stage, in plain integer arithmetic.
   task automatic model_step(input bit r, input logic [1:0] s,
                             input int re, input int im, input bit v);
      ent_t h, t;
      if (r) begin
         model_reset();
         return;
      end
      h = q.pop_front();
      if (s == 2'd0) begin
         t.re = re; t.im = im; t.v = v;
         exp_re = h.re; exp_im = h.im; exp_v = h.v;
      end else if (s == 2'd1) begin
         exp_re = (h.re + re) >>> 1;
         exp_im = (h.im + im) >>> 1;
         exp_v  = v;
         t.re = (h.re - re) >>> 1;
         t.im = (h.im - im) >>> 1;
         t.v  = v;
      end else begin
         t.re = 0; t.im = 0; t.v = 1'b0;
         exp_re = h.re; exp_im = h.im; exp_v = h.v;
      end
      q.push_back(t);
   endtask

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one cycle, advance the model at the edge, check outputs 1ns later.
   task automatic step(input bit r, input logic [1:0] s,
                       input int re, input int im, input bit v);
      logic [W-1:0] er, ei;
      rst = r; sel = s; in_re = W'(re); in_im = W'(im); in_valid = v;
      @(posedge clk);
      model_step(r, s, re, im, v);
      #1;
      er = W'(exp_re);
      ei = W'(exp_im);
      chk("model", {out_re, out_im, out_valid}, {er, ei, exp_v});
   endtask

   function automatic int rnd();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   initial begin
      rst = 1'b1; sel = 2'd2; in_re = '0; in_im = '0; in_valid = 1'b0;
      model_reset();

      // Reset with random inputs, then one cycle after and a full flush.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'($urandom_range(3)), rnd(), rnd(), 1'($urandom_range(1)));
         chk("rst_zero", {out_re, out_im, out_valid}, '0);
      end
      step(1'b0, 2'd2, rnd(), rnd(), 1'b1);
      chk("post_rst_zero", {out_re, out_im, out_valid}, '0);
      for (int i = 0; i < D; i++) begin
         step(1'b0, 2'd2, rnd(), rnd(), 1'b1);
         chk("rst_flush_v", 40'(out_valid), 40'(0));
      end

      // Basic butterfly: ramp fill, offset ramp butterfly, flush.
      for (int k = 0; k < D; k++) step(1'b0, 2'd0, k, 0, 1'b1);
      for (int k = 0; k < D; k++) begin
         step(1'b0, 2'd1, 100 + k, 0, 1'b1);
         chk("bfly_sum", {out_re, out_valid}, {16'(k + 50), 1'b1});
      end
      for (int k = 0; k < D; k++) begin
         step(1'b0, 2'd2, 0, 0, 1'b0);
         chk("bfly_diff", {out_re, out_valid}, {16'(-50), 1'b1});
      end
      step(1'b0, 2'd2, 0, 0, 1'b0);
      chk("after_flush_v", 40'(out_valid), 40'(0));

      // Rounding and extremes in the first four slots.
      step(1'b0, 2'd0, 32767, 0, 1'b1);
      step(1'b0, 2'd0, -32768, 0, 1'b1);
      step(1'b0, 2'd0, 1, 0, 1'b1);
      step(1'b0, 2'd0, -1, 0, 1'b1);
      for (int k = 4; k < D; k++) step(1'b0, 2'd0, rnd(), rnd(), 1'b1);
      step(1'b0, 2'd1, 32767, 0, 1'b1);
      chk("ext_sum_max", 40'(out_re), 40'(16'sd32767));
      step(1'b0, 2'd1, 32767, 0, 1'b1);
      chk("ext_sum_mix", 40'(out_re), 40'(16'hFFFF));
      step(1'b0, 2'd1, 0, 0, 1'b1);
      chk("ext_sum_p1", 40'(out_re), 40'(0));
      step(1'b0, 2'd1, 0, 0, 1'b1);
      chk("ext_sum_m1", 40'(out_re), 40'(16'hFFFF));
      for (int k = 4; k < D; k++) step(1'b0, 2'd1, rnd(), rnd(), 1'b1);
      step(1'b0, 2'd2, 0, 0, 1'b0);
      chk("ext_diff_max", 40'(out_re), 40'(0));
      step(1'b0, 2'd2, 0, 0, 1'b0);
      chk("ext_diff_mix", 40'(out_re), 40'(16'h8000));
      step(1'b0, 2'd2, 0, 0, 1'b0);
      chk("ext_diff_p1", 40'(out_re), 40'(0));
      step(1'b0, 2'd2, 0, 0, 1'b0);
      chk("ext_diff_m1", 40'(out_re), 40'(16'hFFFF));
      for (int k = 4; k < D; k++) step(1'b0, 2'd2, 0, 0, 1'b0);

      // Validity: invalid fill slot 5 only; then invalid butterfly slot 5 too.
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < D; k++) step(1'b0, 2'd0, rnd(), rnd(), k != 5);
         for (int k = 0; k < D; k++) begin
            step(1'b0, 2'd1, rnd(), rnd(), !(c == 1 && k == 5));
            if (k == 5) chk("v_bfly5", 40'(out_valid), 40'(c == 0));
         end
         for (int k = 0; k < D; k++) begin
            step(1'b0, 2'd2, 0, 0, 1'b0);
            if (k == 5) chk("v_flush5", 40'(out_valid), 40'(c == 0));
         end
      end

      // sel=3 against sel=2 with identical data.
      for (int c = 0; c < 2; c++) begin
         process p;
         p = process::self();
         p.srandom(1234);
         for (int k = 0; k < D; k++) step(1'b0, 2'd0, rnd(), rnd(), 1'b1);
         for (int k = 0; k < D; k++) step(1'b0, 2'd1, rnd(), rnd(), 1'b1);
         for (int k = 0; k < 2 * D; k++) begin
            step(1'b0, (c == 0) ? 2'd2 : 2'd3, rnd(), rnd(), 1'b1);
            if (c == 0) begin
               rec2_re[k] = out_re; rec2_im[k] = out_im;
            end else begin
               rec3_re[k] = out_re; rec3_im[k] = out_im;
            end
         end
      end
      for (int k = 0; k < 2 * D; k++)
         chk("sel3_vs_sel2", {rec3_re[k], rec3_im[k]}, {rec2_re[k], rec2_im[k]});

      // Reset after 8 butterfly cycles: nothing valid comes out afterwards.
      for (int k = 0; k < D; k++) step(1'b0, 2'd0, rnd(), rnd(), 1'b1);
      for (int k = 0; k < 8; k++) step(1'b0, 2'd1, rnd(), rnd(), 1'b1);
      step(1'b1, 2'd1, rnd(), rnd(), 1'b1);
      for (int k = 0; k < 2 * D; k++) begin
         step(1'b0, 2'd2, rnd(), rnd(), 1'b1);
         chk("midrst_v", 40'(out_valid), 40'(0));
      end

      // Continuous random frames.
      for (int f = 0; f < 10; f++) begin
         for (int k = 0; k < D; k++)
            step(1'b0, 2'd0, rnd(), rnd(), $urandom_range(7) != 0);
         for (int k = 0; k < D; k++)
            step(1'b0, 2'd1, rnd(), rnd(), $urandom_range(7) != 0);
         for (int k = 0; k < D; k++)
            step(1'b0, 2'($urandom_range(3, 2)), rnd(), rnd(), 1'($urandom_range(1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
